// File: rtl/xor_coder_pkg.sv
// Shared types and helpers for the XOR stream coder: FSM states, mode encodings
// and the rolling-key byte arithmetic.
package xor_coder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    localparam logic MODE_REPEAT = 1'b0;
    localparam logic MODE_ROLL   = 1'b1;

    // Key byte advanced by the number of completed passes over the key, wrapping at 8 bits.
    function automatic logic [7:0] roll_key_byte(input logic [7:0] key_byte,
                                                 input int unsigned pass);
        return key_byte + pass[7:0];
    endfunction

endpackage

// File: rtl/xor_stream_coder_if.sv
// Job request/result bundle between the message-entry logic and the coder.
interface xor_stream_coder_if #(
    parameter int unsigned MSG_BYTES = 8,
    parameter int unsigned KEY_BYTES = 1
);
    localparam int unsigned LEN_W = $clog2(MSG_BYTES + 1);

    logic                   ena;
    logic                   start;
    logic                   mode;
    logic [LEN_W-1:0]       len;
    logic [MSG_BYTES*8-1:0] message;
    logic [KEY_BYTES*8-1:0] key;
    logic [MSG_BYTES*8-1:0] coded_message;
    logic                   busy;
    logic                   done;

    modport master (
        output ena, start, mode, len, message, key,
        input  coded_message, busy, done
    );

    modport slave (
        input  ena, start, mode, len, message, key,
        output coded_message, busy, done
    );

endinterface

// File: rtl/xor_key_sched.sv
// Combinational key-byte generator: key bytes for message bytes idx .. idx+BYTES_PER_CYCLE-1.
module xor_key_sched
    import xor_coder_pkg::*;
#(
    parameter int unsigned KEY_BYTES       = 1,
    parameter int unsigned BYTES_PER_CYCLE = 1,
    parameter int unsigned IDX_W           = 4
) (
    input  logic [KEY_BYTES*8-1:0]       key,
    input  logic                         mode,
    input  logic [IDX_W-1:0]             idx,
    output logic [BYTES_PER_CYCLE*8-1:0] key_bytes
);

    int unsigned pos;
    logic [7:0]  base;

    always_comb begin
        key_bytes = '0;
        pos       = 0;
        base      = '0;
        for (int b = 0; b < int'(BYTES_PER_CYCLE); b++) begin
            pos  = 32'(idx) + 32'(b);
            base = key[8*(pos % KEY_BYTES) +: 8];
            key_bytes[8*b +: 8] = (mode == MODE_ROLL) ? roll_key_byte(base, pos / KEY_BYTES)
                                                      : base;
        end
    end

endmodule

// File: rtl/xor_stream_coder.sv
// N-byte XOR message coder with repeating or rolling multi-byte key,
// BYTES_PER_CYCLE bytes per enabled clock, start/busy/done handshake.
module xor_stream_coder
    import xor_coder_pkg::*;
#(
    parameter int unsigned MSG_BYTES       = 8,
    parameter int unsigned KEY_BYTES       = 1,
    parameter int unsigned BYTES_PER_CYCLE = 1
) (
    input logic               clk,
    input logic               rst,
    xor_stream_coder_if.slave bus
);

    localparam int unsigned LEN_W = $clog2(MSG_BYTES + 1);
    localparam int unsigned IDX_W = $clog2(MSG_BYTES + BYTES_PER_CYCLE + 1);

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [LEN_W-1:0]       len_q;
    logic [KEY_BYTES*8-1:0] key_q;
    logic                   mode_q;
    logic [MSG_BYTES*8-1:0] coded_q;
    logic                   busy_q;
    logic                   done_q;

    logic [LEN_W-1:0]             len_clamped;
    logic [IDX_W-1:0]             idx_next;
    logic [BYTES_PER_CYCLE*8-1:0] key_bytes;
    logic [MSG_BYTES*8-1:0]       coded_run;
    int unsigned                  pos;

    assign len_clamped = (32'(bus.len) > MSG_BYTES) ? LEN_W'(MSG_BYTES) : bus.len;
    assign idx_next    = idx_q + IDX_W'(BYTES_PER_CYCLE);

    xor_key_sched #(
        .KEY_BYTES       (KEY_BYTES),
        .BYTES_PER_CYCLE (BYTES_PER_CYCLE),
        .IDX_W           (IDX_W)
    ) u_key_sched (
        .key       (key_q),
        .mode      (mode_q),
        .idx       (idx_q),
        .key_bytes (key_bytes)
    );

    // coded_q already holds the plaintext, so coding a byte is an in-place XOR.
    always_comb begin
        coded_run = coded_q;
        pos       = 0;
        for (int b = 0; b < int'(BYTES_PER_CYCLE); b++) begin
            pos = 32'(idx_q) + 32'(b);
            if (pos < 32'(len_q)) begin
                coded_run[8*pos +: 8] = coded_q[8*pos +: 8] ^ key_bytes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= '0;
            key_q   <= '0;
            mode_q  <= MODE_REPEAT;
            coded_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.ena) begin
            unique case (state_q)
                StIdle: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start) begin
                        key_q   <= bus.key;
                        mode_q  <= bus.mode;
                        len_q   <= len_clamped;
                        coded_q <= bus.message;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        if (bus.len == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    coded_q <= coded_run;
                    idx_q   <= idx_next;
                    if (idx_next >= IDX_W'(len_q)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.coded_message = coded_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_xor_stream_coder.sv
// Directed bench: three coder configurations (defaults, 2-byte key, 2 bytes/cycle)
// driven in parallel, the selected one checked against hand-computed vectors.
module tb_xor_stream_coder;

    typedef struct {
        int          sel;
        logic [63:0] msg;
        logic [15:0] key;
        logic        mode;
        logic [3:0]  len;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        start;
    logic        mode;
    logic [3:0]  len;
    logic [63:0] message;
    logic [15:0] key;
    int          cur_sel;
    int          checks;
    int          errors;

    logic [63:0] sel_coded;
    logic        sel_busy;
    logic        sel_done;

    xor_stream_coder_if #(.MSG_BYTES(8), .KEY_BYTES(1)) if_a ();
    xor_stream_coder_if #(.MSG_BYTES(8), .KEY_BYTES(2)) if_b ();
    xor_stream_coder_if #(.MSG_BYTES(8), .KEY_BYTES(1)) if_c ();

    assign if_a.ena = ena;     assign if_b.ena = ena;     assign if_c.ena = ena;
    assign if_a.start = start; assign if_b.start = start; assign if_c.start = start;
    assign if_a.mode = mode;   assign if_b.mode = mode;   assign if_c.mode = mode;
    assign if_a.len = len;     assign if_b.len = len;     assign if_c.len = len;
    assign if_a.message = message;
    assign if_b.message = message;
    assign if_c.message = message;
    assign if_a.key = key[7:0];
    assign if_b.key = key;
    assign if_c.key = key[7:0];

    xor_stream_coder #(.MSG_BYTES(8), .KEY_BYTES(1), .BYTES_PER_CYCLE(1)) dut_a (
        .clk (clk), .rst (rst), .bus (if_a)
    );
    xor_stream_coder #(.MSG_BYTES(8), .KEY_BYTES(2), .BYTES_PER_CYCLE(1)) dut_b (
        .clk (clk), .rst (rst), .bus (if_b)
    );
    xor_stream_coder #(.MSG_BYTES(8), .KEY_BYTES(1), .BYTES_PER_CYCLE(2)) dut_c (
        .clk (clk), .rst (rst), .bus (if_c)
    );

    assign sel_coded = (cur_sel == 1) ? if_b.coded_message :
                       (cur_sel == 2) ? if_c.coded_message : if_a.coded_message;
    assign sel_busy  = (cur_sel == 1) ? if_b.busy : (cur_sel == 2) ? if_c.busy : if_a.busy;
    assign sel_done  = (cur_sel == 1) ? if_b.done : (cur_sel == 2) ? if_c.done : if_a.done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Pulses start, then samples #1 after each edge until done (bounded).
    task automatic run_job(input vec_t v, input int stall_at, input bit poke,
                           output logic [63:0] res, output int lat, output int bcnt,
                           output bit timeout);
        cur_sel = v.sel;
        message = v.msg;
        key     = v.key;
        mode    = v.mode;
        len     = v.len;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        lat     = 0;
        bcnt    = 0;
        timeout = 1'b1;
        while (lat < 200) begin
            if (sel_busy) bcnt++;
            if (sel_done) begin
                timeout = 1'b0;
                break;
            end
            if (poke) begin
                start   = (lat == 2);
                key     = ~key;
                message = {message[31:0], message[63:32]} ^ 64'h5a;
                mode    = ~mode;
                len     = 4'd1;
            end
            if (lat == stall_at) ena = 1'b0;
            if (lat == stall_at + 3) ena = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        res   = sel_coded;
        start = 1'b0;
        ena   = 1'b1;
    endtask

    task automatic job_and_check(input vec_t v, input int stall_at, input bit poke,
                                 input string name);
        logic [63:0] res;
        int          lat;
        int          bcnt;
        bit          timeout;
        int          idle_busy;
        run_job(v, stall_at, poke, res, lat, bcnt, timeout);
        check({name, "_done_seen"}, 64'(timeout), 64'd0);
        check({name, "_coded"}, res, v.exp);
        check({name, "_latency"}, 64'(lat), 64'(v.lat));
        check({name, "_busy_cycles"}, 64'(bcnt), 64'(v.lat + 1));
        @(posedge clk); #1;
        check({name, "_done_one_cycle"}, 64'(sel_done), 64'd0);
        check({name, "_busy_after"}, 64'(sel_busy), 64'd0);
        idle_busy = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (sel_busy || sel_done) idle_busy++;
        end
        check({name, "_no_second_job"}, 64'(idle_busy), 64'd0);
        check({name, "_coded_held"}, sel_coded, v.exp);
    endtask

    vec_t vecs[9];

    initial begin
        vec_t        sv;
        int          dcnt;
        int          guard;
        checks  = 0;
        errors  = 0;
        cur_sel = 0;
        rst     = 1'b1;
        ena     = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        len     = 4'd0;
        message = '0;
        key     = '0;

        vecs[0] = '{0, 64'h0123456789ABCDEF, 16'h00A5, 1'b0, 4'd8,  64'hA486E0C22C0E684A, 8};
        vecs[1] = '{1, 64'h0000000000000000, 16'h0201, 1'b1, 4'd6,  64'h0000040303020201, 6};
        vecs[2] = '{2, 64'h1111111111111111, 16'h00FF, 1'b0, 4'd3,  64'h1111111111EEEEEE, 2};
        vecs[3] = '{0, 64'hDEADBEEF00112233, 16'h00A5, 1'b0, 4'd0,  64'hDEADBEEF00112233, 0};
        vecs[4] = '{0, 64'h0000000000000000, 16'h0010, 1'b1, 4'd4,  64'h0000000013121110, 4};
        vecs[5] = '{2, 64'h0000000000000000, 16'h000F, 1'b0, 4'd8,  64'h0F0F0F0F0F0F0F0F, 4};
        vecs[6] = '{0, 64'h0000000000000000, 16'h0001, 1'b0, 4'd12, 64'h0101010101010101, 8};
        vecs[7] = '{1, 64'hFFFFFFFFFFFFFFFF, 16'h0201, 1'b0, 4'd5,  64'hFFFFFFFEFDFEFDFE, 5};
        vecs[8] = '{1, 64'h0000000000000000, 16'hFFFE, 1'b1, 4'd8,  64'h0201010000FFFFFE, 8};

        repeat (2) @(posedge clk);
        #1;
        check("reset_coded", if_a.coded_message, 64'd0);
        check("reset_busy", 64'(if_a.busy), 64'd0);
        check("reset_done", 64'(if_a.done), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            job_and_check(vecs[i], -1, 1'b0, $sformatf("vec%0d", i));
        end

        // Stall three cycles mid-run while scrambling inputs and pulsing start.
        sv     = vecs[0];
        sv.lat = 11;
        job_and_check(sv, 3, 1'b1, "stall_poke");

        // Held start: one idle cycle between back-to-back jobs.
        cur_sel = 2;
        message = vecs[2].msg;
        key     = vecs[2].key;
        mode    = vecs[2].mode;
        len     = vecs[2].len;
        start   = 1'b1;
        guard   = 0;
        @(posedge clk); #1;
        while (!sel_done && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("held_done_seen", 64'(sel_done), 64'd1);
        @(posedge clk); #1;
        check("held_idle_gap", 64'(sel_busy), 64'd0);
        @(posedge clk); #1;
        check("held_restart", 64'(sel_busy), 64'd1);
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("held_second_coded", sel_coded, vecs[2].exp);

        // Asynchronous reset at RUN index 4.
        cur_sel = 0;
        message = vecs[0].msg;
        key     = vecs[0].key;
        mode    = vecs[0].mode;
        len     = vecs[0].len;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_busy", 64'(sel_busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_coded", sel_coded, 64'd0);
        check("abort_busy", 64'(sel_busy), 64'd0);
        check("abort_done", 64'(sel_done), 64'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        dcnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (sel_done || sel_busy) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);
        job_and_check(vecs[0], -1, 1'b0, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
